// File: rtl/dds_phase_update_ctrl.sv
// Queues timed DDS profile updates and computes the phase the live accumulator
// will hold at each switch time, then commits the new profile at that time.
module dds_phase_update_ctrl #(
  parameter int MAC_LATENCY = 3,
  parameter int FIFO_DEPTH  = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [47:0] timestamp_counter,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [47:0] s_freq,
  input  logic [13:0] s_phase,
  input  logic [47:0] s_time,
  input  logic        s_clear,
  output logic [47:0] mac_a,
  output logic [47:0] mac_b,
  output logic [13:0] mac_c,
  output logic [47:0] mac_d,
  output logic [47:0] mac_e,
  input  logic [47:0] mac_result,
  output logic [47:0] prof_time_offset,
  output logic [47:0] prof_freq,
  output logic [47:0] prof_acc_phase,
  output logic [13:0] prof_phase,
  output logic        update_done,
  output logic        late_error
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int LAT_W = $clog2(MAC_LATENCY + 2);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [LAT_W-1:0] LAST_CALC = LAT_W'(MAC_LATENCY);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_ARMED,
    ST_COMMIT
  } state_t;

  typedef struct packed {
    logic [47:0] freq;
    logic [13:0] phase;
    logic [47:0] switchTime;
    logic        clr;
  } entry_t;

  entry_t           r_fifoMem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [CNT_W-1:0] r_count;
  logic             r_readyEn;

  state_t           r_state;
  state_t           w_nextState;
  logic [LAT_W-1:0] r_calcCnt;
  logic [47:0]      r_snapshot;
  logic             r_entryCycle;

  logic [47:0]      r_profTimeOffset;
  logic [47:0]      r_profFreq;
  logic [47:0]      r_profAccPhase;
  logic [13:0]      r_profPhase;

  entry_t           w_head;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_calcLast;

  assign w_head     = r_fifoMem[r_rdPtr];
  assign w_empty    = (r_count == '0);
  assign s_ready    = r_readyEn && (r_count != DEPTH_CNT);
  assign w_push     = s_valid && s_ready;
  assign w_pop      = (r_state == ST_COMMIT);
  assign w_calcLast = (r_state == ST_CALC) && (r_calcCnt == LAST_CALC);

  // Storage needs no reset: the pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifoMem[r_wrPtr] <= '{freq: s_freq, phase: s_phase, switchTime: s_time, clr: s_clear};
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wrPtr   <= '0;
      r_rdPtr   <= '0;
      r_count   <= '0;
      r_readyEn <= 1'b0;
    end else begin
      r_readyEn <= 1'b1;
      if (w_push) begin
        r_wrPtr <= (r_wrPtr == LAST_PTR) ? '0 : r_wrPtr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rdPtr <= (r_rdPtr == LAST_PTR) ? '0 : r_rdPtr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_nextState = w_head.clr ? ST_ARMED : ST_CALC;
        end
      end
      ST_CALC: begin
        if (w_calcLast) begin
          w_nextState = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (timestamp_counter >= w_head.switchTime) begin
          w_nextState = ST_COMMIT;
        end
      end
      ST_COMMIT: w_nextState = ST_IDLE;
      default:   w_nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state      <= ST_IDLE;
      r_calcCnt    <= '0;
      r_snapshot   <= '0;
      r_entryCycle <= 1'b0;
    end else begin
      r_state      <= w_nextState;
      r_calcCnt    <= (r_state == ST_CALC) ? r_calcCnt + LAT_W'(1) : '0;
      r_entryCycle <= (r_state == ST_IDLE) && !w_empty;
      if ((r_state == ST_IDLE) && !w_empty && w_head.clr) begin
        r_snapshot <= '0;
      end else if (w_calcLast) begin
        r_snapshot <= mac_result;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_profTimeOffset <= '0;
      r_profFreq       <= '0;
      r_profAccPhase   <= '0;
      r_profPhase      <= '0;
    end else if (r_state == ST_COMMIT) begin
      r_profTimeOffset <= w_head.switchTime;
      r_profFreq       <= w_head.freq;
      r_profAccPhase   <= r_snapshot;
      r_profPhase      <= w_head.phase;
    end
  end

  // The snapshot MAC sees the current profile projected to the head's switch time.
  always_comb begin
    mac_a = '0;
    mac_b = '0;
    mac_c = '0;
    mac_d = '0;
    mac_e = '0;
    if (r_state == ST_CALC) begin
      mac_a = r_profTimeOffset;
      mac_b = r_profFreq;
      mac_c = r_profPhase;
      mac_d = w_head.switchTime;
      mac_e = r_profAccPhase;
    end
  end

  assign prof_time_offset = r_profTimeOffset;
  assign prof_freq        = r_profFreq;
  assign prof_acc_phase   = r_profAccPhase;
  assign prof_phase       = r_profPhase;
  assign update_done      = (r_state == ST_COMMIT);
  assign late_error       = r_entryCycle && (timestamp_counter > w_head.switchTime);

endmodule

// File: doc/dds_phase_update_ctrl.md
DDS_PHASE_UPDATE_CTRL -- requirements
Module: dds_phase_update_ctrl

Interface
REQ-001 SHALL have parameter MAC_LATENCY, default 3: cycles from stable phase-MAC inputs to a valid mac_result.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2: number of pending update entries.
REQ-003 SHALL have port clk, input, 1: the single clock.
REQ-004 SHALL have port resetn, input, 1: reset, synchronous and active-low.
REQ-005 SHALL have port timestamp_counter, input, 48: current system time.
REQ-006 SHALL have port s_valid, input, 1: update request valid.
REQ-007 SHALL have port s_ready, output, 1: update request accepted.
REQ-008 SHALL have ports s_freq (input, 48), s_phase (input, 14), s_time (input, 48): new frequency, new phase offset, switch time.
REQ-009 SHALL have port s_clear, input, 1: reset the accumulated phase to 0 at switch.
REQ-010 SHALL have ports mac_a, mac_b, mac_d, mac_e (output, 48) and mac_c (output, 14): time offset, frequency, timestamp, accumulated phase, phase to the snapshot phase-MAC.
REQ-011 SHALL have port mac_result, input, 48: snapshot phase-MAC result.
REQ-012 SHALL have ports prof_time_offset, prof_freq, prof_acc_phase (output, 48) and prof_phase (output, 14): active profile for the live phase-MAC.
REQ-013 SHALL have ports update_done and late_error, output, 1: single-cycle pulses.

Function
REQ-014 SHALL buffer accepted requests in a FIFO_DEPTH-entry FIFO; handshake occurs when s_valid && s_ready; s_ready = !full.
- Accept when full and pop in the same cycle: SHALL be prevented, because s_ready depends only on full.
REQ-015 SHALL implement FSM IDLE, CALC, ARMED, COMMIT.
- IDLE -> CALC when the FIFO is non-empty and head s_clear=0.
- IDLE -> ARMED when the FIFO is non-empty and head s_clear=1, with snapshot = 0.
REQ-016 In CALC, SHALL hold the following constant for exactly MAC_LATENCY+1 cycles, then capture mac_result into snapshot and go to ARMED:
- mac_a=prof_time_offset, mac_b=prof_freq, mac_c=prof_phase, mac_d=head.s_time, mac_e=prof_acc_phase.
REQ-017 Outside CALC, SHALL drive mac_a..mac_e to 0.
REQ-018 In ARMED, SHALL go to COMMIT on the first cycle timestamp_counter >= head.s_time (unsigned 48-bit compare).
REQ-019 In COMMIT (1 cycle), SHALL do the following, then return to IDLE:
- load prof_time_offset=head.s_time, prof_freq=head.s_freq, prof_phase=head.s_phase, prof_acc_phase=snapshot;
- pop the FIFO;
- pulse update_done.
REQ-020 SHALL pulse late_error in the cycle of CALC or ARMED entry if timestamp_counter > head.s_time at that cycle; the update still completes, committing at the earliest cycle.
REQ-021 Profile outputs SHALL change only in the COMMIT cycle and SHALL be registered (visible the cycle after COMMIT).
REQ-022 All arithmetic SHALL be unsigned 48-bit; the snapshot carries mac_result unmodified, so phase wrap-around is modulo 2^48.
REQ-023 Back-to-back entries SHALL be processed in FIFO order; the CALC of entry n+1 uses the profile committed by entry n.
REQ-024 Minimum IDLE-to-COMMIT latency SHALL be MAC_LATENCY+3 cycles for a non-clear entry and 2 cycles for a clear entry.

Reset
REQ-025 While resetn=0 at a clk edge, SHALL do the following, including mid-operation, with no completion or pulse of an in-flight update:
- FSM -> IDLE, FIFO emptied;
- s_ready=0 during reset, 1 from the first cycle after release;
- all prof_* and mac_* = 0;
- update_done=0, late_error=0, snapshot=0.

Verification
REQ-026 Reset release, then s_clear=1, freq=0x1000, phase=0x100, time=100 at counter 50 -> commit at counter 100, prof_acc_phase=0, update_done 1 cycle, no late_error.
REQ-027 Second update, freq=0x2000, time=300 -> mac_d=300, mac_a=100, mac_b=0x1000 held MAC_LATENCY+1 cycles; prof_acc_phase equals a reference-model mac_result at commit (counter 300).
REQ-028 Update with time=10 issued at counter 500 -> late_error pulse, commit within MAC_LATENCY+3 cycles, profile loaded.
REQ-029 Push 3 updates with s_valid held -> s_ready=0 after 2 accepts, third accepted after the first COMMIT, commits in order.
REQ-030 resetn=0 during CALC, then release -> outputs all 0, no update_done, FIFO empty, s_ready=1.
REQ-031 Accumulated phase near 2^48-1 plus a large freq×time -> prof_acc_phase wraps modulo 2^48 and matches the model.
